// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared state encoding for the instruction sequencer.
package seq_ctrl_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SeqIdle      = 3'd0,
        SeqFetch     = 3'd1,
        SeqDecode    = 3'd2,
        SeqExec      = 3'd3,
        SeqWriteBack = 3'd4,
        SeqHalt      = 3'd5,
        SeqPause     = 3'd6
    } seq_state_t;

    // Plain-vector constants so the FSM register stays a legacy-friendly logic vector.
    localparam logic [SEQ_STATE_W-1:0] StIdle   = SeqIdle;
    localparam logic [SEQ_STATE_W-1:0] StFetch  = SeqFetch;
    localparam logic [SEQ_STATE_W-1:0] StDecode = SeqDecode;
    localparam logic [SEQ_STATE_W-1:0] StExec   = SeqExec;
    localparam logic [SEQ_STATE_W-1:0] StWb     = SeqWriteBack;
    localparam logic [SEQ_STATE_W-1:0] StHalt   = SeqHalt;
    localparam logic [SEQ_STATE_W-1:0] StPause  = SeqPause;

endpackage

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: fetch handshake and pipeline strobe bundle between the sequencer (master)
// and the program memory / decoder / ALU / register file side (slave).
interface seq_ctrl_if #(
    parameter int unsigned PC_W    = 5,
    parameter int unsigned INSTR_W = 6
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instr;
    logic               id_ce;
    logic               ex_ce;
    logic               ex_busy;
    logic               br_taken;
    logic [PC_W-1:0]    br_target;
    logic               halt_req;
    logic               wb_ce;

    modport master (
        output imem_req, imem_addr, instr, id_ce, ex_ce, wb_ce,
        input  imem_ack, imem_data, ex_busy, br_taken, br_target, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, instr, id_ce, ex_ce, wb_ce,
        output imem_ack, imem_data, ex_busy, br_taken, br_target, halt_req
    );
endinterface

// File: rtl/seq_pc_reg.sv
// seq_pc_reg: program counter with clear, load and increment by PC_INC.
// The incremented value is exposed with its carry-out so the caller can detect overflow.
module seq_pc_reg #(
    parameter int unsigned PC_W   = 5,
    parameter int unsigned PC_INC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            ld_i,
    input  logic [PC_W-1:0] ld_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] inc_val_o,
    output logic            ovf_o
);

    logic [PC_W-1:0] pc_q, pc_d;

    // pc + PC_INC computed one bit wider; the top bit is the overflow flag.
    always_comb begin
        {ovf_o, inc_val_o} = {1'b0, pc_q} + (PC_W + 1)'(PC_INC);
    end

    // Next PC: clear beats load beats increment.
    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (ld_i) begin
            pc_d = ld_val_i;
        end else if (inc_i) begin
            pc_d = inc_val_o;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction sequencer FETCH/DECODE/EXEC/WRITE_BACK with variable-latency fetch,
// exec stall, branches, HALT, end-of-memory wrap/halt and program-load abort.
// Optional single-step mode: define SEQ_CTRL_STEP_EN to add step_i and the PAUSE state.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 5,
    parameter int unsigned INSTR_W = 6,
    parameter int unsigned PC_INC  = 1,
    parameter int unsigned WRAP_EN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SEQ_CTRL_STEP_EN
    input  logic                   step_i,
`endif
    input  logic                   prog_load_i,
    input  logic                   start_i,
    seq_ctrl_if.master             bus,
    output logic [PC_W-1:0]        pc_o,
    output logic [SEQ_STATE_W-1:0] state_o,
    output logic                   halted_o
);

    logic [SEQ_STATE_W-1:0] state_q, state_d;
    logic [INSTR_W-1:0]     instr_q, instr_d;
    logic [PC_W:0]          npc_q, npc_d;
    logic                   br_q, br_d;

    logic            pc_clr, pc_ld, pc_inc;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            pc_ovf;

    seq_pc_reg #(
        .PC_W   (PC_W),
        .PC_INC (PC_INC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (pc_clr),
        .ld_i      (pc_ld),
        .ld_val_i  (npc_q[PC_W-1:0]),
        .inc_i     (pc_inc),
        .pc_o      (pc),
        .inc_val_o (pc_next),
        .ovf_o     (pc_ovf)
    );

    // Next-state, IR capture and PC control; prog_load overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        br_d    = br_q;
        pc_clr  = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        if (prog_load_i && (state_q != StIdle)) begin
            state_d = StIdle;
            pc_clr  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && !prog_load_i) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (bus.imem_ack) begin
                        instr_d = bus.imem_data;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    state_d = StExec;
                end
                StExec: begin
                    if (!bus.ex_busy) begin
                        if (bus.halt_req) begin
                            state_d = StHalt;
                        end else begin
                            npc_d   = bus.br_taken ? {1'b0, bus.br_target} : {pc_ovf, pc_next};
                            br_d    = bus.br_taken;
                            state_d = StWb;
                        end
                    end
                end
                StWb: begin
                    if (npc_q[PC_W] && !br_q && (WRAP_EN == 0)) begin
                        state_d = StHalt;
                    end else begin
                        // Dropping the carry bit gives the wrap to 0.
                        if (br_q) begin
                            pc_ld = 1'b1;
                        end else begin
                            pc_inc = 1'b1;
                        end
`ifdef SEQ_CTRL_STEP_EN
                        state_d = StPause;
`else
                        state_d = StFetch;
`endif
                    end
                end
                StHalt: begin
                    if (start_i) begin
                        pc_clr  = 1'b1;
                        state_d = StFetch;
                    end
                end
                StPause: begin
`ifdef SEQ_CTRL_STEP_EN
                    if (step_i) begin
                        state_d = StFetch;
                    end
`else
                    state_d = StIdle;
`endif
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // FSM, instruction register and pending next-PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            instr_q <= '0;
            npc_q   <= '0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            br_q    <= br_d;
        end
    end

    // Strobes decode the registered state only, so reset drops them immediately.
    always_comb begin
        bus.imem_req  = (state_q == StFetch);
        bus.imem_addr = pc;
        bus.instr     = instr_q;
        bus.id_ce     = (state_q == StDecode);
        bus.ex_ce     = (state_q == StExec);
        bus.wb_ce     = (state_q == StWb);
        pc_o          = pc;
        state_o       = state_q;
        halted_o      = (state_q == StHalt);
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed self-checking bench for seq_ctrl. A second instance with WRAP_EN=1
// shares all stimulus and is checked at the end-of-memory boundary.
module tb_seq_ctrl;
    import seq_ctrl_pkg::*;

    localparam int unsigned PC_W    = 5;
    localparam int unsigned INSTR_W = 6;
`ifdef SEQ_CTRL_STEP_EN
    localparam int CPI = 5;
    localparam logic [2:0] AFTER_WB = StPause;
`else
    localparam int CPI = 4;
    localparam logic [2:0] AFTER_WB = StFetch;
`endif

    logic clk = 1'b0;
    logic rst;
    logic prog_load, start;
`ifdef SEQ_CTRL_STEP_EN
    logic step;
`endif
    logic ack, busy, br, halt;
    logic [INSTR_W-1:0] data;
    logic [PC_W-1:0] target;

    logic [PC_W-1:0] pc, pc_w;
    logic [2:0] state, state_w;
    logic halted, halted_w;
    logic [3:0] strb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_if ();
    seq_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_if_w ();

    assign u_if.imem_ack    = ack;
    assign u_if.imem_data   = data;
    assign u_if.ex_busy     = busy;
    assign u_if.br_taken    = br;
    assign u_if.br_target   = target;
    assign u_if.halt_req    = halt;
    assign u_if_w.imem_ack  = ack;
    assign u_if_w.imem_data = data;
    assign u_if_w.ex_busy   = busy;
    assign u_if_w.br_taken  = br;
    assign u_if_w.br_target = target;
    assign u_if_w.halt_req  = halt;

    assign strb = {u_if.imem_req, u_if.id_ce, u_if.ex_ce, u_if.wb_ce};

    seq_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PC_INC(1), .WRAP_EN(0)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_CTRL_STEP_EN
        .step_i      (step),
`endif
        .prog_load_i (prog_load),
        .start_i     (start),
        .bus         (u_if),
        .pc_o        (pc),
        .state_o     (state),
        .halted_o    (halted)
    );

    seq_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PC_INC(1), .WRAP_EN(1)) dut_wrap (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ_CTRL_STEP_EN
        .step_i      (step),
`endif
        .prog_load_i (prog_load),
        .start_i     (start),
        .bus         (u_if_w),
        .pc_o        (pc_w),
        .state_o     (state_w),
        .halted_o    (halted_w)
    );

    // Bounded wait (at negedges) for the main DUT to reach a state.
    task automatic wait_state(input logic [2:0] s, input string what);
        int n = 0;
        while (state !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state !== s) begin
            failures++;
            $display("FAIL wait_%s: state=%0d required=%0d", what, state, s);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== StIdle || pc !== 5'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d pc=%0d required 0/0", state, pc);
        end
        checks++;
        if (strb !== 4'b0000 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: strb=%b halted=%b required 0000/0", strb, halted);
        end
        checks++;
        if (u_if.instr !== 6'd0 || state_w !== StIdle) begin
            failures++;
            $display("FAIL reset_instr: instr=%h wrap_state=%0d required 0/0", u_if.instr, state_w);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== StIdle) begin
            failures++;
            $display("FAIL idle_hold: state=%0d required %0d", state, StIdle);
        end
    endtask

    task automatic test_sequence();
        logic [2:0] es;
        logic [3:0] eb;
        logic [5:0] d;
        data = 6'h10;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < CPI; c++) begin
                es = (c < 4) ? 3'(c + 1) : StPause;
                eb = (c < 4) ? (4'b1000 >> c) : 4'b0000;
                d  = 6'h10 + 6'(i);
                checks++;
                if (state !== es || strb !== eb || pc !== 5'(i)) begin
                    failures++;
                    $display("FAIL seq_i%0d_c%0d: state=%0d strb=%b pc=%0d required %0d/%b/%0d",
                             i, c, state, strb, pc, es, eb, i);
                end
                if (c == 1) begin
                    checks++;
                    if (u_if.instr !== d) begin
                        failures++;
                        $display("FAIL seq_instr%0d: instr=%h required %h", i, u_if.instr, d);
                    end
                end
                if (c == CPI - 1) data = 6'h11 + 6'(i);
                @(negedge clk);
            end
        end
        checks++;
        if (state !== StFetch || pc !== 5'd3) begin
            failures++;
            $display("FAIL seq_end: state=%0d pc=%0d required 1/3", state, pc);
        end
    endtask

    task automatic test_ack_delay();
        int n = 0;
        rst = 1'b1;
        ack = 1'b1;
        data = 6'h15;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        while (!(state === StFetch && pc === 5'd2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        ack = 1'b0;
        data = 6'h3F;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (state !== StFetch || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 5'd2 ||
                u_if.instr !== 6'h15) begin
                failures++;
                $display("FAIL ack_wait%0d: state=%0d req=%b addr=%0d instr=%h required 1/1/2/15",
                         k, state, u_if.imem_req, u_if.imem_addr, u_if.instr);
            end
            if (k == 3) begin
                ack = 1'b1;
                data = 6'h2B;
            end
            @(negedge clk);
        end
        checks++;
        if (state !== StDecode || u_if.instr !== 6'h2B || u_if.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL ack_latch: state=%0d instr=%h req=%b required 2/2b/0",
                     state, u_if.instr, u_if.imem_req);
        end
    endtask

    task automatic test_exec_stall();
        busy = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (state !== StExec || u_if.ex_ce !== 1'b1 || u_if.wb_ce !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d: state=%0d ex_ce=%b wb_ce=%b required 3/1/0",
                         k, state, u_if.ex_ce, u_if.wb_ce);
            end
            if (k == 5) begin
                busy = 1'b0;
                br = 1'b1;
                target = 5'd17;
            end
            @(negedge clk);
        end
        checks++;
        if (state !== StWb || u_if.wb_ce !== 1'b1 || pc !== 5'd2) begin
            failures++;
            $display("FAIL stall_wb: state=%0d wb_ce=%b pc=%0d required 4/1/2",
                     state, u_if.wb_ce, pc);
        end
        br = 1'b0;
        target = 5'd0;
        wait_state(StFetch, "branch_fetch");
        checks++;
        if (pc !== 5'd17 || u_if.imem_addr !== 5'd17) begin
            failures++;
            $display("FAIL branch_pc: pc=%0d addr=%0d required 17/17", pc, u_if.imem_addr);
        end
    endtask

    task automatic test_ovf();
        br = 1'b1;
        target = 5'd31;
        wait_state(StWb, "to31_wb");
        br = 1'b0;
        target = 5'd0;
        wait_state(StFetch, "to31_fetch");
        checks++;
        if (pc !== 5'd31) begin
            failures++;
            $display("FAIL ovf_pc31: pc=%0d required 31", pc);
        end
        wait_state(StWb, "ovf_wb");
        checks++;
        if (u_if.wb_ce !== 1'b1) begin
            failures++;
            $display("FAIL ovf_wb_ce: wb_ce=%b required 1", u_if.wb_ce);
        end
        @(negedge clk);
        checks++;
        if (state !== StHalt || halted !== 1'b1 || pc !== 5'd31 || strb !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_halt: state=%0d halted=%b pc=%0d strb=%b required 5/1/31/0000",
                     state, halted, pc, strb);
        end
        checks++;
        if (state_w !== AFTER_WB || pc_w !== 5'd0 || halted_w !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pc: state=%0d pc=%0d halted=%b required %0d/0/0",
                     state_w, pc_w, halted_w, AFTER_WB);
        end
        pulse_start();
        checks++;
        if (state !== StFetch || pc !== 5'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_restart: state=%0d pc=%0d halted=%b required 1/0/0",
                     state, pc, halted);
        end
    endtask

    task automatic test_halt_priority();
        br = 1'b1;
        target = 5'd6;
        wait_state(StWb, "to6_wb");
        br = 1'b0;
        wait_state(StFetch, "to6_fetch");
        wait_state(StExec, "pc6_exec");
        checks++;
        if (pc !== 5'd6) begin
            failures++;
            $display("FAIL pc6: pc=%0d required 6", pc);
        end
        halt = 1'b1;
        br = 1'b1;
        target = 5'd9;
        @(negedge clk);
        checks++;
        if (state !== StHalt || pc !== 5'd6 || u_if.wb_ce !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_prio: state=%0d pc=%0d wb_ce=%b halted=%b required 5/6/0/1",
                     state, pc, u_if.wb_ce, halted);
        end
        halt = 1'b0;
        br = 1'b0;
        target = 5'd0;
        @(negedge clk);
        checks++;
        if (state !== StHalt || u_if.wb_ce !== 1'b0 || pc !== 5'd6) begin
            failures++;
            $display("FAIL halt_hold: state=%0d wb_ce=%b pc=%0d required 5/0/6",
                     state, u_if.wb_ce, pc);
        end
        pulse_start();
    endtask

    task automatic test_prog_load();
        wait_state(StWb, "pl_wb");
        wait_state(StFetch, "pl_fetch");
        wait_state(StExec, "pl_exec");
        busy = 1'b1;
        checks++;
        if (pc !== 5'd1) begin
            failures++;
            $display("FAIL pl_pc1: pc=%0d required 1", pc);
        end
        prog_load = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== StIdle || pc !== 5'd0 || u_if.ex_ce !== 1'b0 || strb !== 4'b0000) begin
            failures++;
            $display("FAIL pl_abort: state=%0d pc=%0d ex_ce=%b strb=%b required 0/0/0/0000",
                     state, pc, u_if.ex_ce, strb);
        end
        busy = 1'b0;
        pulse_start();
        checks++;
        if (state !== StIdle) begin
            failures++;
            $display("FAIL pl_blocks_start: state=%0d required 0", state);
        end
        prog_load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        pulse_start();
        wait_state(StWb, "ar_wb");
        checks++;
        if (u_if.wb_ce !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre: wb_ce=%b required 1", u_if.wb_ce);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (u_if.wb_ce !== 1'b0 || state !== StIdle || pc !== 5'd0) begin
            failures++;
            $display("FAIL ar_drop: wb_ce=%b state=%0d pc=%0d required 0/0/0",
                     u_if.wb_ce, state, pc);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef SEQ_CTRL_STEP_EN
    task automatic test_step();
        step = 1'b0;
        pulse_start();
        wait_state(StWb, "step_wb");
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state !== StPause || strb !== 4'b0000) begin
                failures++;
                $display("FAIL pause%0d: state=%0d strb=%b required 6/0000", k, state, strb);
            end
            @(negedge clk);
        end
        step = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== StFetch || pc !== 5'd1) begin
            failures++;
            $display("FAIL step_go: state=%0d pc=%0d required 1/1", state, pc);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        prog_load = 1'b0;
        start = 1'b0;
`ifdef SEQ_CTRL_STEP_EN
        step = 1'b1;
`endif
        ack = 1'b1;
        busy = 1'b0;
        br = 1'b0;
        halt = 1'b0;
        data = 6'h00;
        target = 5'd0;
        test_reset();
        test_sequence();
        test_ack_delay();
        test_exec_stall();
        test_ovf();
        test_halt_priority();
        test_prog_load();
        test_async_reset();
`ifdef SEQ_CTRL_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
